// File: rtl/axi4_arbiter.sv
// 2:1 round-robin AXI4 arbiter: one transaction (read or write burst) in flight at a time.
// The granted master is wired straight through to the slave port; the other master sees ready=0.
module axi4_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // master 0 (IFU)
  input  logic [ADDR_WIDTH-1:0]   m0_araddr_i,
  input  logic [ID_WIDTH-1:0]     m0_arid_i,
  input  logic [7:0]              m0_arlen_i,
  input  logic [2:0]              m0_arsize_i,
  input  logic [1:0]              m0_arburst_i,
  input  logic                    m0_arvalid_i,
  output logic                    m0_arready_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic [1:0]              m0_rresp_o,
  output logic                    m0_rlast_o,
  output logic [ID_WIDTH-1:0]     m0_rid_o,
  output logic                    m0_rvalid_o,
  input  logic                    m0_rready_i,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr_i,
  input  logic [ID_WIDTH-1:0]     m0_awid_i,
  input  logic [7:0]              m0_awlen_i,
  input  logic [2:0]              m0_awsize_i,
  input  logic [1:0]              m0_awburst_i,
  input  logic                    m0_awvalid_i,
  output logic                    m0_awready_o,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
  input  logic                    m0_wlast_i,
  input  logic                    m0_wvalid_i,
  output logic                    m0_wready_o,
  output logic [1:0]              m0_bresp_o,
  output logic [ID_WIDTH-1:0]     m0_bid_o,
  output logic                    m0_bvalid_o,
  input  logic                    m0_bready_i,
  // master 1 (LSU)
  input  logic [ADDR_WIDTH-1:0]   m1_araddr_i,
  input  logic [ID_WIDTH-1:0]     m1_arid_i,
  input  logic [7:0]              m1_arlen_i,
  input  logic [2:0]              m1_arsize_i,
  input  logic [1:0]              m1_arburst_i,
  input  logic                    m1_arvalid_i,
  output logic                    m1_arready_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic [1:0]              m1_rresp_o,
  output logic                    m1_rlast_o,
  output logic [ID_WIDTH-1:0]     m1_rid_o,
  output logic                    m1_rvalid_o,
  input  logic                    m1_rready_i,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr_i,
  input  logic [ID_WIDTH-1:0]     m1_awid_i,
  input  logic [7:0]              m1_awlen_i,
  input  logic [2:0]              m1_awsize_i,
  input  logic [1:0]              m1_awburst_i,
  input  logic                    m1_awvalid_i,
  output logic                    m1_awready_o,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
  input  logic                    m1_wlast_i,
  input  logic                    m1_wvalid_i,
  output logic                    m1_wready_o,
  output logic [1:0]              m1_bresp_o,
  output logic [ID_WIDTH-1:0]     m1_bid_o,
  output logic                    m1_bvalid_o,
  input  logic                    m1_bready_i,
  // downstream slave
  output logic [ADDR_WIDTH-1:0]   s_araddr_o,
  output logic [ID_WIDTH-1:0]     s_arid_o,
  output logic [7:0]              s_arlen_o,
  output logic [2:0]              s_arsize_o,
  output logic [1:0]              s_arburst_o,
  output logic                    s_arvalid_o,
  input  logic                    s_arready_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  input  logic [1:0]              s_rresp_i,
  input  logic                    s_rlast_i,
  input  logic [ID_WIDTH-1:0]     s_rid_i,
  input  logic                    s_rvalid_i,
  output logic                    s_rready_o,
  output logic [ADDR_WIDTH-1:0]   s_awaddr_o,
  output logic [ID_WIDTH-1:0]     s_awid_o,
  output logic [7:0]              s_awlen_o,
  output logic [2:0]              s_awsize_o,
  output logic [1:0]              s_awburst_o,
  output logic                    s_awvalid_o,
  input  logic                    s_awready_i,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
  output logic                    s_wlast_o,
  output logic                    s_wvalid_o,
  input  logic                    s_wready_i,
  input  logic [1:0]              s_bresp_i,
  input  logic [ID_WIDTH-1:0]     s_bid_i,
  input  logic                    s_bvalid_i,
  output logic                    s_bready_o
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic       pick;
  logic [1:0] req, awreq;
  logic       rd, wr;

  assign awreq = {m1_awvalid_i, m0_awvalid_i};
  assign req   = {m1_arvalid_i, m0_arvalid_i} | awreq;
  assign rd    = (state_q == StRd);
  assign wr    = (state_q == StWr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    pick    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          // Tie goes to whoever was not served last; writes beat reads within a master.
          pick    = (req == 2'b11) ? ~last_q : req[1];
          gnt_d   = pick;
          state_d = awreq[pick] ? StWr : StRd;
        end
      end
      StRd: begin
        if (s_rvalid_i && s_rready_o && s_rlast_i) begin
          state_d = StIdle;
          last_d  = gnt_q;
        end
      end
      StWr: begin
        if (s_bvalid_i && s_bready_o) begin
          state_d = StIdle;
          last_d  = gnt_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request-side channels: payload muxed freely, valids gated by state.
  assign s_araddr_o  = gnt_q ? m1_araddr_i  : m0_araddr_i;
  assign s_arid_o    = gnt_q ? m1_arid_i    : m0_arid_i;
  assign s_arlen_o   = gnt_q ? m1_arlen_i   : m0_arlen_i;
  assign s_arsize_o  = gnt_q ? m1_arsize_i  : m0_arsize_i;
  assign s_arburst_o = gnt_q ? m1_arburst_i : m0_arburst_i;
  assign s_arvalid_o = rd & (gnt_q ? m1_arvalid_i : m0_arvalid_i);
  assign s_rready_o  = rd & (gnt_q ? m1_rready_i  : m0_rready_i);
  assign s_awaddr_o  = gnt_q ? m1_awaddr_i  : m0_awaddr_i;
  assign s_awid_o    = gnt_q ? m1_awid_i    : m0_awid_i;
  assign s_awlen_o   = gnt_q ? m1_awlen_i   : m0_awlen_i;
  assign s_awsize_o  = gnt_q ? m1_awsize_i  : m0_awsize_i;
  assign s_awburst_o = gnt_q ? m1_awburst_i : m0_awburst_i;
  assign s_awvalid_o = wr & (gnt_q ? m1_awvalid_i : m0_awvalid_i);
  assign s_wdata_o   = gnt_q ? m1_wdata_i   : m0_wdata_i;
  assign s_wstrb_o   = gnt_q ? m1_wstrb_i   : m0_wstrb_i;
  assign s_wlast_o   = gnt_q ? m1_wlast_i   : m0_wlast_i;
  assign s_wvalid_o  = wr & (gnt_q ? m1_wvalid_i : m0_wvalid_i);
  assign s_bready_o  = wr & (gnt_q ? m1_bready_i : m0_bready_i);

  // Response payload is broadcast; only the granted master ever sees a valid or ready.
  assign m0_arready_o = rd & ~gnt_q & s_arready_i;
  assign m0_rvalid_o  = rd & ~gnt_q & s_rvalid_i;
  assign m0_awready_o = wr & ~gnt_q & s_awready_i;
  assign m0_wready_o  = wr & ~gnt_q & s_wready_i;
  assign m0_bvalid_o  = wr & ~gnt_q & s_bvalid_i;
  assign m1_arready_o = rd & gnt_q & s_arready_i;
  assign m1_rvalid_o  = rd & gnt_q & s_rvalid_i;
  assign m1_awready_o = wr & gnt_q & s_awready_i;
  assign m1_wready_o  = wr & gnt_q & s_wready_i;
  assign m1_bvalid_o  = wr & gnt_q & s_bvalid_i;

  assign m0_rdata_o = s_rdata_i;
  assign m0_rresp_o = s_rresp_i;
  assign m0_rlast_o = s_rlast_i;
  assign m0_rid_o   = s_rid_i;
  assign m0_bresp_o = s_bresp_i;
  assign m0_bid_o   = s_bid_i;
  assign m1_rdata_o = s_rdata_i;
  assign m1_rresp_o = s_rresp_i;
  assign m1_rlast_o = s_rlast_i;
  assign m1_rid_o   = s_rid_i;
  assign m1_bresp_o = s_bresp_i;
  assign m1_bid_o   = s_bid_i;

endmodule

// File: tb/tb_axi4_arbiter.sv
// Bench for axi4_arbiter: random master requests and a random-latency slave, checked against a
// transaction-level round-robin model.
module tb_axi4_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]   m_araddr [2];
  logic [IW-1:0]   m_arid [2];
  logic [7:0]      m_arlen [2];
  logic [2:0]      m_arsize [2];
  logic [1:0]      m_arburst [2];
  logic            m_arvalid [2];
  logic            m_arready [2];
  logic [AW-1:0]   m_rdata [2];
  logic [1:0]      m_rresp [2];
  logic            m_rlast [2];
  logic [IW-1:0]   m_rid [2];
  logic            m_rvalid [2];
  logic            m_rready [2];
  logic [AW-1:0]   m_awaddr [2];
  logic [IW-1:0]   m_awid [2];
  logic [7:0]      m_awlen [2];
  logic [2:0]      m_awsize [2];
  logic [1:0]      m_awburst [2];
  logic            m_awvalid [2];
  logic            m_awready [2];
  logic [AW-1:0]   m_wdata [2];
  logic [AW/8-1:0] m_wstrb [2];
  logic            m_wlast [2];
  logic            m_wvalid [2];
  logic            m_wready [2];
  logic [1:0]      m_bresp [2];
  logic [IW-1:0]   m_bid [2];
  logic            m_bvalid [2];
  logic            m_bready [2];

  logic [AW-1:0] s_araddr, s_awaddr, s_rdata, s_wdata;
  logic [IW-1:0] s_arid, s_awid, s_rid, s_bid;
  logic [7:0] s_arlen, s_awlen;
  logic [2:0] s_arsize, s_awsize;
  logic [1:0] s_arburst, s_awburst, s_rresp, s_bresp;
  logic [AW/8-1:0] s_wstrb;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

  // Reference model: outstanding requests per master and who was served last.
  bit pend_rd [2];
  bit pend_wr [2];
  int last_m;
  logic [AW-1:0] wb [2][4];
  bit use_dead;

  axi4_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_araddr_i(m_araddr[0]), .m0_arid_i(m_arid[0]), .m0_arlen_i(m_arlen[0]),
    .m0_arsize_i(m_arsize[0]), .m0_arburst_i(m_arburst[0]), .m0_arvalid_i(m_arvalid[0]),
    .m0_arready_o(m_arready[0]), .m0_rdata_o(m_rdata[0]), .m0_rresp_o(m_rresp[0]),
    .m0_rlast_o(m_rlast[0]), .m0_rid_o(m_rid[0]), .m0_rvalid_o(m_rvalid[0]),
    .m0_rready_i(m_rready[0]), .m0_awaddr_i(m_awaddr[0]), .m0_awid_i(m_awid[0]),
    .m0_awlen_i(m_awlen[0]), .m0_awsize_i(m_awsize[0]), .m0_awburst_i(m_awburst[0]),
    .m0_awvalid_i(m_awvalid[0]), .m0_awready_o(m_awready[0]), .m0_wdata_i(m_wdata[0]),
    .m0_wstrb_i(m_wstrb[0]), .m0_wlast_i(m_wlast[0]), .m0_wvalid_i(m_wvalid[0]),
    .m0_wready_o(m_wready[0]), .m0_bresp_o(m_bresp[0]), .m0_bid_o(m_bid[0]),
    .m0_bvalid_o(m_bvalid[0]), .m0_bready_i(m_bready[0]),
    .m1_araddr_i(m_araddr[1]), .m1_arid_i(m_arid[1]), .m1_arlen_i(m_arlen[1]),
    .m1_arsize_i(m_arsize[1]), .m1_arburst_i(m_arburst[1]), .m1_arvalid_i(m_arvalid[1]),
    .m1_arready_o(m_arready[1]), .m1_rdata_o(m_rdata[1]), .m1_rresp_o(m_rresp[1]),
    .m1_rlast_o(m_rlast[1]), .m1_rid_o(m_rid[1]), .m1_rvalid_o(m_rvalid[1]),
    .m1_rready_i(m_rready[1]), .m1_awaddr_i(m_awaddr[1]), .m1_awid_i(m_awid[1]),
    .m1_awlen_i(m_awlen[1]), .m1_awsize_i(m_awsize[1]), .m1_awburst_i(m_awburst[1]),
    .m1_awvalid_i(m_awvalid[1]), .m1_awready_o(m_awready[1]), .m1_wdata_i(m_wdata[1]),
    .m1_wstrb_i(m_wstrb[1]), .m1_wlast_i(m_wlast[1]), .m1_wvalid_i(m_wvalid[1]),
    .m1_wready_o(m_wready[1]), .m1_bresp_o(m_bresp[1]), .m1_bid_o(m_bid[1]),
    .m1_bvalid_o(m_bvalid[1]), .m1_bready_i(m_bready[1]),
    .s_araddr_o(s_araddr), .s_arid_o(s_arid), .s_arlen_o(s_arlen), .s_arsize_o(s_arsize),
    .s_arburst_o(s_arburst), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
    .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rlast_i(s_rlast), .s_rid_i(s_rid),
    .s_rvalid_i(s_rvalid), .s_rready_o(s_rready), .s_awaddr_o(s_awaddr), .s_awid_o(s_awid),
    .s_awlen_o(s_awlen), .s_awsize_o(s_awsize), .s_awburst_o(s_awburst),
    .s_awvalid_o(s_awvalid), .s_awready_i(s_awready), .s_wdata_o(s_wdata),
    .s_wstrb_o(s_wstrb), .s_wlast_o(s_wlast), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
    .s_bresp_i(s_bresp), .s_bid_i(s_bid), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {s_arvalid, s_awvalid, s_wvalid, s_bready, s_rready,
              m_arready[0], m_awready[0], m_wready[0], m_bvalid[0], m_rvalid[0],
              m_arready[1], m_awready[1], m_wready[1], m_bvalid[1], m_rvalid[1]}, 64'd0);
  endtask

  task automatic clear_all();
    for (int m = 0; m < 2; m++) begin
      m_araddr[m] = '0; m_arid[m] = '0; m_arlen[m] = '0; m_arsize[m] = '0;
      m_arburst[m] = '0; m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
      m_awaddr[m] = '0; m_awid[m] = '0; m_awlen[m] = '0; m_awsize[m] = '0;
      m_awburst[m] = '0; m_awvalid[m] = 1'b0; m_wdata[m] = '0; m_wstrb[m] = '0;
      m_wlast[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0;
      pend_rd[m] = 1'b0; pend_wr[m] = 1'b0;
    end
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bid = '0; s_bvalid = 1'b0;
  endtask

  // kind: 0 none, 1 read, 2 write, 3 read and write together
  task automatic new_req(input int m, input int kind);
    if (kind == 1 || kind == 3) begin
      m_araddr[m] = $urandom; m_arid[m] = IW'($urandom); m_arlen[m] = 8'($urandom_range(0, 3));
      m_arsize[m] = 3'd2; m_arburst[m] = 2'd1; m_arvalid[m] = 1'b1; pend_rd[m] = 1'b1;
    end
    if (kind >= 2) begin
      m_awaddr[m] = $urandom; m_awid[m] = IW'($urandom); m_awlen[m] = 8'($urandom_range(0, 3));
      m_awsize[m] = 3'd2; m_awburst[m] = 2'd1; m_awvalid[m] = 1'b1; pend_wr[m] = 1'b1;
      for (int i = 0; i < 4; i++) wb[m][i] = $urandom;
      m_wdata[m] = wb[m][0]; m_wstrb[m] = 4'($urandom); m_wlast[m] = (m_awlen[m] == 8'd0);
      m_wvalid[m] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    last_m = 1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Called in an IDLE cycle: predicts the winner, then runs its whole transaction.
  task automatic run_round(input bit abort);
    int w, l, sbeats, rsent, w_idx;
    bit r0, r1, done, aw_done, w_done, ar_done, was_last, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    chk_quiet("idle_quiet");
    r0 = pend_rd[0] | pend_wr[0];
    r1 = pend_rd[1] | pend_wr[1];
    if (!r0 && !r1) begin
      tick();
      return;
    end
    if (r0 && r1) w = (last_m == 0) ? 1 : 0;
    else w = r0 ? 0 : 1;
    l = 1 - w;
    tick();
    done = 0; aw_done = 0; w_done = 0; ar_done = 0; sbeats = 0; rsent = 0; w_idx = 0;
    if (pend_wr[w]) begin
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        s_awready = 1'($urandom_range(0, 1));
        s_wready = 1'($urandom_range(0, 1));
        if (aw_done && w_done && !s_bvalid) begin
          s_bvalid = 1'b1; s_bid = m_awid[w]; s_bresp = 2'($urandom);
        end
        for (int m = 0; m < 2; m++) begin
          m_bready[m] = 1'($urandom_range(0, 1)); m_rready[m] = 1'($urandom_range(0, 1));
        end
        #1;
        chk("s_awvalid", s_awvalid, m_awvalid[w]);
        if (m_awvalid[w]) chk("s_aw_payload", {s_awaddr, s_awid, s_awlen, s_awsize, s_awburst},
                              {m_awaddr[w], m_awid[w], m_awlen[w], m_awsize[w], m_awburst[w]});
        chk("m_awready", m_awready[w], s_awready);
        chk("s_wvalid", s_wvalid, m_wvalid[w]);
        chk("m_wready", m_wready[w], s_wready);
        chk("m_bvalid", m_bvalid[w], s_bvalid);
        if (s_bvalid) chk("m_b_payload", {m_bid[w], m_bresp[w]}, {m_awid[w], s_bresp});
        chk("s_bready", s_bready, m_bready[w]);
        chk("wr_blocked", {m_awready[l], m_wready[l], m_bvalid[l], s_arvalid, s_rready,
                           m_arready[0], m_arready[1], m_rvalid[0], m_rvalid[1]}, 64'd0);
        if (s_wvalid && s_wready && sbeats < 4) begin
          chk("s_w_beat", {s_wdata, s_wstrb, s_wlast},
              {wb[w][sbeats], m_wstrb[w], 1'(sbeats == int'(m_awlen[w]))});
          sbeats++;
        end
        aw_hs = m_awvalid[w] && s_awready;
        w_hs = m_wvalid[w] && s_wready;
        b_hs = s_bvalid && m_bready[w];
        tick();
        if (aw_hs) begin
          m_awvalid[w] = 1'b0; aw_done = 1;
        end
        if (w_hs) begin
          w_idx++;
          if (w_idx > int'(m_awlen[w])) begin
            m_wvalid[w] = 1'b0; m_wlast[w] = 1'b0; w_done = 1;
          end else begin
            m_wdata[w] = wb[w][w_idx]; m_wlast[w] = (w_idx == int'(m_awlen[w]));
          end
        end
        if (b_hs) begin
          s_bvalid = 1'b0; done = 1; pend_wr[w] = 1'b0;
        end
      end
      chk("wr_beat_count", 64'(sbeats), 64'(m_awlen[w]) + 64'd1);
    end else begin
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
        s_arready = 1'($urandom_range(0, 1));
        if (ar_done && !s_rvalid && rsent <= int'(m_arlen[w]) && $urandom_range(0, 3) != 0) begin
          s_rvalid = 1'b1; s_rdata = use_dead ? 32'hDEAD_BEEF : $urandom; s_rid = m_arid[w];
          s_rresp = 2'($urandom); s_rlast = (rsent == int'(m_arlen[w]));
        end
        for (int m = 0; m < 2; m++) begin
          m_bready[m] = 1'($urandom_range(0, 1)); m_rready[m] = 1'($urandom_range(0, 1));
        end
        if (abort) m_rready[w] = 1'b0;
        #1;
        if (abort && s_rvalid) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mid_burst", {s_arvalid, s_rready, m_rvalid[0], m_rvalid[1]}, 64'd0);
          chk_quiet("rst_quiet");
          clear_all();
          last_m = 1;
          tick();
          tick();
          rst_n = 1'b1;
          return;
        end
        chk("s_arvalid", s_arvalid, m_arvalid[w]);
        if (m_arvalid[w]) chk("s_ar_payload", {s_araddr, s_arid, s_arlen, s_arsize, s_arburst},
                              {m_araddr[w], m_arid[w], m_arlen[w], m_arsize[w], m_arburst[w]});
        chk("m_arready", m_arready[w], s_arready);
        chk("m_rvalid", m_rvalid[w], s_rvalid);
        if (s_rvalid) chk("m_r_payload", {m_rdata[w], m_rid[w], m_rresp[w], m_rlast[w]},
                          {s_rdata, m_arid[w], s_rresp, 1'(rsent == int'(m_arlen[w]))});
        chk("s_rready", s_rready, m_rready[w]);
        chk("rd_blocked", {m_arready[l], m_rvalid[l], s_awvalid, s_wvalid, s_bready,
                           m_awready[0], m_awready[1], m_wready[0], m_wready[1],
                           m_bvalid[0], m_bvalid[1]}, 64'd0);
        ar_hs = m_arvalid[w] && s_arready;
        r_hs = s_rvalid && m_rready[w];
        was_last = s_rlast;
        tick();
        if (ar_hs) begin
          m_arvalid[w] = 1'b0; ar_done = 1; pend_rd[w] = 1'b0;
        end
        if (r_hs) begin
          s_rvalid = 1'b0; s_rlast = 1'b0; rsent++;
          if (was_last) done = 1;
        end
      end
    end
    chk("txn_done", 64'(done), 64'd1);
    if (!done) begin
      do_reset();
      return;
    end
    last_m = w;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && (pend_rd[0] | pend_wr[0] | pend_rd[1] | pend_wr[1]); k++)
      run_round(1'b0);
  endtask

  initial begin
    clear_all();
    last_m = 1;
    use_dead = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset_quiet");
    rst_n = 1'b1;

    // Contention from reset: m0 first, then alternation while both keep requesting.
    new_req(0, 1);
    new_req(1, 1);
    run_round(1'b0);
    new_req(0, 1);
    run_round(1'b0);
    new_req(1, 1);
    run_round(1'b0);
    drain();

    // Random mix of reads, writes and read+write pairs from both masters.
    repeat (150) begin
      for (int m = 0; m < 2; m++)
        if (!(pend_rd[m] | pend_wr[m])) new_req(m, $urandom_range(0, 3));
      run_round(1'b0);
    end
    drain();

    // 4-beat write burst from m1.
    new_req(1, 2);
    m_awlen[1] = 8'd3;
    m_wlast[1] = 1'b0;
    run_round(1'b0);
    // Read and write together from one master: write goes first.
    new_req(1, 3);
    run_round(1'b0);
    run_round(1'b0);
    drain();

    // Reset while read data is being returned.
    new_req(0, 1);
    m_arlen[0] = 8'd3;
    run_round(1'b1);

    // Single read after reset.
    new_req(0, 1);
    m_araddr[0] = 32'h3000_0000;
    m_arlen[0] = 8'd0;
    use_dead = 1'b1;
    run_round(1'b0);
    use_dead = 1'b0;
    run_round(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
